usb_rx_ctrl: RTL and testbench

- Packet-level control FSM for the USB RX path.
- Sequences the bit timer: starts it on the first D+ edge of a packet and stops it on EOP or error.
- Validates the SYNC byte and the PID, strobes received data bytes into the RX FIFO, enforces the maximum packet length, and reports packet status to the AHB-Lite endpoint side.
- Sits between the edge/EOP detectors, timer and shift register on one side, and the RX FIFO and endpoint register logic on the other.

---
 rtl/usb_rx_ctrl_pkg.sv | 37 +++
 rtl/usb_rx_ctrl_if.sv | 29 ++
 rtl/usb_rx_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_ctrl_pkg.sv
// Shared types and constants for the USB RX packet controller.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_RX,
    SYNC_CHK,
    PID_RX,
    PID_CHK,
    DATA_RX,
    DATA_STORE,
    EOP_WAIT,
    DONE,
    ERR_WAIT,
    ERR_IDLE
  } rx_ctrl_state_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

  // Upper nibble must be the complement of the PID code, and the code must be supported.
  function automatic logic pid_valid(input logic [7:0] b);
    logic [3:0] p;
    p = b[3:0];
    return (b[7:4] == ~p) &&
           (p == PID_OUT || p == PID_IN || p == PID_DATA0 || p == PID_DATA1 ||
            p == PID_ACK || p == PID_NAK || p == PID_STALL);
  endfunction

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// Bundle between the RX front end / FIFO / endpoint logic and the packet controller.
interface usb_rx_ctrl_if;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_complete;
  logic [7:0] rcv_data;
  logic       fifo_full;
  logic       enable_timer;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [3:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       flush;

  modport master (
    output d_edge, eop, shift_enable, byte_complete, rcv_data, fifo_full,
    input  enable_timer, rcving, w_enable, r_error, rx_packet,
           rx_data_ready, rx_transfer_active, flush
  );

  modport slave (
    input  d_edge, eop, shift_enable, byte_complete, rcv_data, fifo_full,
    output enable_timer, rcving, w_enable, r_error, rx_packet,
           rx_data_ready, rx_transfer_active, flush
  );
endinterface

// File: rtl/usb_rx_ctrl.sv
// USB RX packet-level control FSM: SYNC/PID validation, payload strobing, length and EOP checks.
//
// state      | meaning
// IDLE       | bus idle, waiting for first D+ edge
// SYNC_RX    | shifting in the SYNC byte
// SYNC_CHK   | compare SYNC byte
// PID_RX     | shifting in the PID byte
// PID_CHK    | validate PID, pick packet type
// DATA_RX    | shifting payload / token bytes
// DATA_STORE | write byte to FIFO, length check
// EOP_WAIT   | expecting EOP, no more bytes
// DONE       | report packet status
// ERR_WAIT   | error seen, waiting for EOP
// ERR_IDLE   | error held, waiting for next packet
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int         MAX_DATA_BYTES = 64,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input logic           clk,
  input logic           n_rst,
  usb_rx_ctrl_if.slave  bus
);

  localparam logic [6:0] LP_MAX_STORE = 7'(MAX_DATA_BYTES + 2);
  localparam logic [6:0] LP_TOKEN_LEN = 7'd2;

  rx_ctrl_state_t r_state;
  logic [2:0]     r_bit_cnt;
  logic [6:0]     r_byte_cnt;
  logic           r_is_data;
  logic           r_enable_timer;
  logic           r_rcving;
  logic           r_w_enable;
  logic           r_err;
  logic [3:0]     r_rx_packet;
  logic           r_rx_data_ready;
  logic           r_rx_transfer_active;
  logic           r_flush;

  logic           w_eop;
  logic [6:0]     w_byte_inc;
  logic [3:0]     w_pid;
  logic           w_pid_data;
  logic           w_pid_token;

  assign w_eop       = bus.eop & bus.shift_enable;
  assign w_byte_inc  = (r_byte_cnt == 7'h7F) ? r_byte_cnt : r_byte_cnt + 7'd1;
  assign w_pid       = bus.rcv_data[3:0];
  assign w_pid_data  = (w_pid == PID_DATA0) || (w_pid == PID_DATA1);
  assign w_pid_token = (w_pid == PID_OUT) || (w_pid == PID_IN);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state              <= IDLE;
      r_bit_cnt            <= 3'd0;
      r_byte_cnt           <= 7'd0;
      r_is_data            <= 1'b0;
      r_enable_timer       <= 1'b0;
      r_rcving             <= 1'b0;
      r_w_enable           <= 1'b0;
      r_err                <= 1'b0;
      r_rx_packet          <= 4'h0;
      r_rx_data_ready      <= 1'b0;
      r_rx_transfer_active <= 1'b0;
      r_flush              <= 1'b0;
    end else begin
      r_w_enable      <= 1'b0;
      r_flush         <= 1'b0;
      r_rx_data_ready <= 1'b0;
      if (bus.byte_complete)
        r_bit_cnt <= 3'd0;
      else if (bus.shift_enable)
        r_bit_cnt <= r_bit_cnt + 3'd1;

      case (r_state)
        IDLE, ERR_IDLE: begin
          if (bus.d_edge) begin
            r_state        <= SYNC_RX;
            r_enable_timer <= 1'b1;
            r_rcving       <= 1'b1;
            r_err          <= 1'b0;
            r_byte_cnt     <= 7'd0;
            r_bit_cnt      <= 3'd0;
            r_is_data      <= 1'b0;
          end
        end
        SYNC_RX, PID_RX: begin
          // A byte finishing on the same strobe as EOP still counts as a byte.
          if (bus.byte_complete) begin
            r_state <= (r_state == SYNC_RX) ? SYNC_CHK : PID_CHK;
          end else if (w_eop) begin
            r_state              <= ERR_WAIT;
            r_err                <= 1'b1;
            r_rx_transfer_active <= 1'b0;
          end
        end
        SYNC_CHK: begin
          if (bus.rcv_data == SYNC_BYTE) begin
            r_state <= PID_RX;
          end else begin
            r_state              <= ERR_WAIT;
            r_err                <= 1'b1;
            r_rx_transfer_active <= 1'b0;
          end
        end
        PID_CHK: begin
          if (pid_valid(bus.rcv_data)) begin
            r_rx_packet <= w_pid;
            r_bit_cnt   <= 3'd0;
            if (w_pid_data) begin
              r_flush              <= 1'b1;
              r_rx_transfer_active <= 1'b1;
              r_is_data            <= 1'b1;
              r_state              <= DATA_RX;
            end else if (w_pid_token) begin
              r_is_data <= 1'b0;
              r_state   <= DATA_RX;
            end else begin
              r_is_data <= 1'b0;
              r_state   <= EOP_WAIT;
            end
          end else begin
            r_state              <= ERR_WAIT;
            r_err                <= 1'b1;
            r_rx_transfer_active <= 1'b0;
          end
        end
        DATA_RX: begin
          if (bus.byte_complete) begin
            r_state <= DATA_STORE;
          end else if (w_eop) begin
            if (r_bit_cnt == 3'd0) begin
              r_state <= EOP_WAIT;
            end else begin
              r_state              <= ERR_WAIT;
              r_err                <= 1'b1;
              r_rx_transfer_active <= 1'b0;
            end
          end
        end
        DATA_STORE: begin
          r_byte_cnt <= w_byte_inc;
          if ((r_is_data && (w_byte_inc > LP_MAX_STORE || bus.fifo_full)) ||
              (!r_is_data && w_byte_inc > LP_TOKEN_LEN)) begin
            r_state              <= ERR_WAIT;
            r_err                <= 1'b1;
            r_rx_transfer_active <= 1'b0;
          end else begin
            r_w_enable <= r_is_data;
            r_state    <= DATA_RX;
          end
        end
        EOP_WAIT: begin
          if (bus.byte_complete) begin
            r_state              <= ERR_WAIT;
            r_err                <= 1'b1;
            r_rx_transfer_active <= 1'b0;
          end else if (w_eop) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (r_is_data) begin
            if (r_byte_cnt >= 7'd2) r_rx_data_ready <= 1'b1;
            else                    r_err           <= 1'b1;
          end
          r_enable_timer       <= 1'b0;
          r_rcving             <= 1'b0;
          r_rx_transfer_active <= 1'b0;
          r_state              <= IDLE;
        end
        ERR_WAIT: begin
          if (w_eop) begin
            r_state        <= ERR_IDLE;
            r_enable_timer <= 1'b0;
            r_rcving       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.enable_timer       = r_enable_timer;
  assign bus.rcving             = r_rcving;
  assign bus.w_enable           = r_w_enable;
  assign bus.r_error            = r_err;
  assign bus.rx_packet          = r_rx_packet;
  assign bus.rx_data_ready      = r_rx_data_ready;
  assign bus.rx_transfer_active = r_rx_transfer_active;
  assign bus.flush              = r_flush;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl: good/bad packets, length limits and mid-packet reset.
module tb_usb_rx_ctrl;

  logic clk = 1'b0;
  logic n_rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt_wen = 0;
  int   cnt_flush = 0;
  int   cnt_rdy = 0;
  logic rdy_timer = 1'b1;

  usb_rx_ctrl_if bus();

  usb_rx_ctrl dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Outputs only change on posedge; sample on the falling edge.
  always @(negedge clk) begin
    if (bus.w_enable) cnt_wen++;
    if (bus.flush) cnt_flush++;
    if (bus.rx_data_ready) begin
      cnt_rdy++;
      rdy_timer = bus.enable_timer;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_edge();
    bus.d_edge = 1'b1;
    cyc();
    bus.d_edge = 1'b0;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.shift_enable = 1'b1;
      cyc();
      bus.shift_enable = 1'b0;
      cyc();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(8);
    bus.rcv_data      = b;
    bus.byte_complete = 1'b1;
    cyc();
    bus.byte_complete = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic send_eop();
    bus.eop = 1'b1;
    send_bits(3);
    bus.eop = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    n_rst = 1'b0;
    repeat (3) cyc();
    outs = {bus.enable_timer, bus.rcving, bus.w_enable, bus.r_error, bus.rx_packet,
            bus.rx_data_ready, bus.rx_transfer_active, bus.flush};
    n_tests++;
    if (outs !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 000", outs);
    end
    n_rst = 1'b1;
    cyc();
  endtask

  task automatic test_good_data0();
    int w0, f0, r0;
    w0 = cnt_wen; f0 = cnt_flush; r0 = cnt_rdy;
    pulse_edge();
    n_tests++;
    if ({bus.enable_timer, bus.rcving} !== 2'b11) begin
      n_fail++;
      $display("FAIL d0_start: timer/rcving got %b expected 11", {bus.enable_timer, bus.rcving});
    end
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    pulse_edge();
    send_byte(8'h22);
    send_byte(8'h33);
    n_tests++;
    if (bus.rx_transfer_active !== 1'b1) begin
      n_fail++;
      $display("FAIL d0_active: got %b expected 1", bus.rx_transfer_active);
    end
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_eop();
    n_tests++;
    if (cnt_wen - w0 != 5) begin
      n_fail++;
      $display("FAIL d0_wen: got %0d expected 5", cnt_wen - w0);
    end
    n_tests++;
    if (cnt_flush - f0 != 1) begin
      n_fail++;
      $display("FAIL d0_flush: got %0d expected 1", cnt_flush - f0);
    end
    n_tests++;
    if (cnt_rdy - r0 != 1) begin
      n_fail++;
      $display("FAIL d0_ready: got %0d expected 1", cnt_rdy - r0);
    end
    n_tests++;
    if (bus.rx_packet !== 4'b0011) begin
      n_fail++;
      $display("FAIL d0_pid: got %b expected 0011", bus.rx_packet);
    end
    n_tests++;
    if ({bus.r_error, bus.enable_timer, bus.rcving, bus.rx_transfer_active} !== 4'b0000) begin
      n_fail++;
      $display("FAIL d0_end: err/timer/rcving/active got %b expected 0000",
               {bus.r_error, bus.enable_timer, bus.rcving, bus.rx_transfer_active});
    end
    n_tests++;
    if (rdy_timer !== 1'b0) begin
      n_fail++;
      $display("FAIL d0_timer_at_ready: got %b expected 0", rdy_timer);
    end
  endtask

  task automatic test_bad_sync();
    int w0;
    w0 = cnt_wen;
    pulse_edge();
    send_byte(8'h81);
    n_tests++;
    if ({bus.r_error, bus.enable_timer} !== 2'b11) begin
      n_fail++;
      $display("FAIL sync_err: err/timer got %b expected 11", {bus.r_error, bus.enable_timer});
    end
    send_eop();
    n_tests++;
    if ({bus.r_error, bus.enable_timer, bus.rcving} !== 3'b100) begin
      n_fail++;
      $display("FAIL sync_after_eop: err/timer/rcving got %b expected 100",
               {bus.r_error, bus.enable_timer, bus.rcving});
    end
    n_tests++;
    if (cnt_wen != w0) begin
      n_fail++;
      $display("FAIL sync_wen: got %0d expected 0", cnt_wen - w0);
    end
  endtask

  task automatic test_pid_fail();
    int f0;
    f0 = cnt_flush;
    pulse_edge();
    n_tests++;
    if (bus.r_error !== 1'b0) begin
      n_fail++;
      $display("FAIL pid_err_cleared: got %b expected 0", bus.r_error);
    end
    send_byte(8'h80);
    send_byte(8'hC2);
    n_tests++;
    if (bus.r_error !== 1'b1) begin
      n_fail++;
      $display("FAIL pid_err: got %b expected 1", bus.r_error);
    end
    n_tests++;
    if (bus.rx_packet !== 4'b0011) begin
      n_fail++;
      $display("FAIL pid_keep: got %b expected 0011", bus.rx_packet);
    end
    n_tests++;
    if (cnt_flush != f0) begin
      n_fail++;
      $display("FAIL pid_flush: got %0d expected 0", cnt_flush - f0);
    end
    send_eop();
  endtask

  task automatic test_early_eop();
    int w0, r0;
    w0 = cnt_wen; r0 = cnt_rdy;
    pulse_edge();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    send_bits(4);
    send_eop();
    n_tests++;
    if ({bus.r_error, bus.enable_timer} !== 2'b10) begin
      n_fail++;
      $display("FAIL early_err: err/timer got %b expected 10", {bus.r_error, bus.enable_timer});
    end
    n_tests++;
    if (cnt_rdy != r0) begin
      n_fail++;
      $display("FAIL early_ready: got %0d expected 0", cnt_rdy - r0);
    end
    n_tests++;
    if (cnt_wen - w0 != 2) begin
      n_fail++;
      $display("FAIL early_wen: got %0d expected 2", cnt_wen - w0);
    end
  endtask

  task automatic test_overlength();
    int w0, r0;
    w0 = cnt_wen; r0 = cnt_rdy;
    pulse_edge();
    send_byte(8'h80);
    send_byte(8'h4B);
    for (int i = 0; i < 66; i++) send_byte(8'(i));
    n_tests++;
    if (bus.r_error !== 1'b0) begin
      n_fail++;
      $display("FAIL over_err_early: got %b expected 0 after 66 bytes", bus.r_error);
    end
    send_byte(8'hEE);
    n_tests++;
    if (cnt_wen - w0 != 66) begin
      n_fail++;
      $display("FAIL over_wen: got %0d expected 66", cnt_wen - w0);
    end
    n_tests++;
    if ({bus.r_error, bus.rx_transfer_active} !== 2'b10) begin
      n_fail++;
      $display("FAIL over_err: err/active got %b expected 10", {bus.r_error, bus.rx_transfer_active});
    end
    n_tests++;
    if (bus.rx_packet !== 4'b1011) begin
      n_fail++;
      $display("FAIL over_pid: got %b expected 1011", bus.rx_packet);
    end
    send_eop();
    n_tests++;
    if ({bus.enable_timer, cnt_rdy - r0 == 0} !== 2'b01) begin
      n_fail++;
      $display("FAIL over_end: timer %b ready pulses %0d expected 0/0", bus.enable_timer, cnt_rdy - r0);
    end
  endtask

  task automatic test_handshake_reset();
    int w0, r0, f0;
    logic [10:0] outs;
    w0 = cnt_wen; r0 = cnt_rdy;
    pulse_edge();
    send_byte(8'h80);
    send_byte(8'hD2);
    send_eop();
    n_tests++;
    if (bus.rx_packet !== 4'b0010) begin
      n_fail++;
      $display("FAIL ack_pid: got %b expected 0010", bus.rx_packet);
    end
    n_tests++;
    if (cnt_rdy != r0 || cnt_wen != w0 || bus.r_error !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_status: ready %0d wen %0d err %b expected 0 0 0",
               cnt_rdy - r0, cnt_wen - w0, bus.r_error);
    end
    pulse_edge();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h55);
    send_bits(3);
    n_rst = 1'b0;
    cyc();
    outs = {bus.enable_timer, bus.rcving, bus.w_enable, bus.r_error, bus.rx_packet,
            bus.rx_data_ready, bus.rx_transfer_active, bus.flush};
    n_tests++;
    if (outs !== 11'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 000", outs);
    end
    f0 = cnt_flush;
    repeat (3) cyc();
    n_rst = 1'b1;
    repeat (3) cyc();
    n_tests++;
    if (cnt_flush != f0 || bus.enable_timer !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: flush %0d timer %b expected 0 0", cnt_flush - f0, bus.enable_timer);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst             = 1'b0;
    bus.d_edge        = 1'b0;
    bus.eop           = 1'b0;
    bus.shift_enable  = 1'b0;
    bus.byte_complete = 1'b0;
    bus.rcv_data      = 8'h00;
    bus.fifo_full     = 1'b0;
    cyc();
    test_reset();
    test_good_data0();
    test_bad_sync();
    test_pid_fail();
    test_early_eop();
    test_overlength();
    test_handshake_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
